mem_bus_arbiter: RTL and testbench

//   Two-master, one-slave arbiter in front of the SRAM model. Master 0 is the IFU

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_grant.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Package: mem_bus_pkg
// Shared types and constants for the two-master SRAM bus arbiter.
//   state_t        arbiter FSM states (IDLE, REQ, RESP)
//   master_t       master identifier (M_IFU = 0, M_LSU = 1)
//   TIMEOUT_RDATA  read data returned with a timeout error response
// Optional feature macro: MEM_BUS_ARB_RR_EN (round-robin grant, see mem_bus_grant).
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic master_t;

    localparam master_t M_IFU = 1'b0;
    localparam master_t M_LSU = 1'b1;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_grant.sv
// Module: mem_bus_grant
// Combinational winner select for the two-master arbiter.
// Ports:
//   if_valid   in   IFU request valid
//   ls_valid   in   LSU request valid
//   prio       in   master preferred on contention (only with MEM_BUS_ARB_RR_EN)
//   any_valid  out  at least one request pending
//   winner     out  granted master (meaningful only when any_valid = 1)
// Macro MEM_BUS_ARB_RR_EN: when defined, contention is resolved by prio
// (round-robin, driven by the top); otherwise LSU always beats IFU.
module mem_bus_grant
    import mem_bus_pkg::*;
(
    input  logic    if_valid,
    input  logic    ls_valid,
`ifdef MEM_BUS_ARB_RR_EN
    input  master_t prio,
`endif
    output logic    any_valid,
    output master_t winner
);

    always_comb begin
        any_valid = if_valid | ls_valid;
        winner    = M_LSU;
`ifdef MEM_BUS_ARB_RR_EN
        if (if_valid && ls_valid) begin
            winner = prio;
        end else if (if_valid) begin
            winner = M_IFU;
        end
`else
        if (if_valid && !ls_valid) begin
            winner = M_IFU;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Module: mem_bus_arbiter
// Two-master, one-slave arbiter in front of the SRAM model. Master 0 is the
// IFU fetch port (read-only), master 1 the LSU data port (read/write). One
// request is in flight at a time: the winner's payload is registered, sent to
// the SRAM, and the response is returned to the winner only as a one-cycle
// ready pulse. If the SRAM does not answer within TIMEOUT_CYC cycles the
// request is dropped and the winner gets an error response.
// Parameters: ADDR_W, DATA_W (wmask = DATA_W/8), TIMEOUT_CYC (0 = wait forever).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_valid/if_addr                 IFU request
//   if_ready/if_rdata/if_err         IFU response
//   ls_valid/ls_addr/ls_wen/
//   ls_wdata/ls_wmask                LSU request
//   ls_ready/ls_rdata/ls_err         LSU response
//   sram_valid/addr/wen/wdata/wmask  request to SRAM
//   sram_ready/sram_rdata            SRAM response
// Macro MEM_BUS_ARB_RR_EN: round-robin arbitration on contention instead of
// fixed LSU > IFU priority.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_valid,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    input  logic                ls_valid,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_ready,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,

    output logic                sram_valid,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_wen,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic [DATA_W/8-1:0] sram_wmask,
    input  logic                sram_ready,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    // The counter holds the number of completed wait cycles, so the request
    // is abandoned in the cycle where it would reach TIMEOUT_CYC.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t              state_q,  state_d;
    master_t             winner_q, winner_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                wen_q,    wen_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [STRB_W-1:0]   wmask_q,  wmask_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic                err_q,    err_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    logic                any_valid;
    master_t             grant_winner;
    logic                timeout_hit;

`ifdef MEM_BUS_ARB_RR_EN
    master_t             ptr_q,    ptr_d;
`endif

    mem_bus_grant u_grant (
        .if_valid  (if_valid),
        .ls_valid  (ls_valid),
`ifdef MEM_BUS_ARB_RR_EN
        .prio      (ptr_q),
`endif
        .any_valid (any_valid),
        .winner    (grant_winner)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
`ifdef MEM_BUS_ARB_RR_EN
        ptr_d    = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d  = REQ;
                    winner_d = grant_winner;
                    err_d    = 1'b0;
                    cnt_d    = '0;
`ifdef MEM_BUS_ARB_RR_EN
                    // Next contention goes to whoever did not win now.
                    ptr_d    = ~grant_winner;
`endif
                    if (grant_winner == M_LSU) begin
                        addr_d  = ls_addr;
                        wen_d   = ls_wen;
                        wdata_d = ls_wdata;
                        wmask_d = ls_wmask;
                    end else begin
                        // Fetch port is read-only: never let it write.
                        addr_d  = if_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end

            REQ: begin
                if (sram_ready) begin
                    state_d = RESP;
                    rdata_d = sram_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = DATA_W'(TIMEOUT_RDATA);
                    err_d   = 1'b1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= M_LSU;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef MEM_BUS_ARB_RR_EN
            ptr_q    <= M_LSU;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`ifdef MEM_BUS_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // Request side: the registered payload is presented only while waiting.
    assign sram_valid = (state_q == REQ);
    assign sram_addr  = addr_q;
    assign sram_wen   = wen_q;
    assign sram_wdata = wdata_q;
    assign sram_wmask = wmask_q;

    // Response side: only the latched winner ever sees ready/rdata/err.
    assign if_ready = (state_q == RESP) && (winner_q == M_IFU);
    assign ls_ready = (state_q == RESP) && (winner_q == M_LSU);
    assign if_rdata = if_ready ? rdata_q : '0;
    assign ls_rdata = ls_ready ? rdata_q : '0;
    assign if_err   = if_ready & err_q;
    assign ls_err   = ls_ready & err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter (fixed-priority build, TIMEOUT_CYC = 4).
// Directed table of single transactions, hand-written corner sequences
// (contention, reset in REQ, stray sram_ready), then a randomized run checked
// against a timestamp-based reference model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_valid;
    logic [31:0] ls_addr;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        sram_valid;
    logic [31:0] sram_addr;
    logic        sram_wen;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wmask;
    logic        sram_ready;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    // SRAM responder control
    int resp_lat    = 0;
    bit stray_ready = 1'b0;
    int sv_k        = 0;

    mem_bus_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .ls_valid   (ls_valid),
        .ls_addr    (ls_addr),
        .ls_wen     (ls_wen),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_ready   (ls_ready),
        .ls_rdata   (ls_rdata),
        .ls_err     (ls_err),
        .sram_valid (sram_valid),
        .sram_addr  (sram_addr),
        .sram_wen   (sram_wen),
        .sram_wdata (sram_wdata),
        .sram_wmask (sram_wmask),
        .sram_ready (sram_ready),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: answers in the (resp_lat+1)-th cycle of a request, i.e.
    // resp_lat = 0 answers in the first cycle sram_valid is seen.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            sv_k = 0;
            sram_ready = 1'b0;
        end else if (sram_valid) begin
            sv_k = sv_k + 1;
            sram_ready = (sv_k == resp_lat + 1);
        end else begin
            sv_k = 0;
            sram_ready = stray_ready;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_lsu;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          lat;
        logic [31:0] srd;
        int          exp_edges;     // accept edge counts as 1
        int          exp_sv_cycles;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic drive_idle();
        if_valid = 1'b0; if_addr  = '0;
        ls_valid = 1'b0; ls_addr  = '0; ls_wen = 1'b0;
        ls_wdata = '0;   ls_wmask = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int got = 0;
        int sv_cnt = 0;
        bit other = 1'b0;
        logic [31:0] rd = '0;
        logic er = 1'b0;
        resp_lat   = v.lat;
        sram_rdata = v.srd;
        if (v.is_lsu) begin
            ls_valid = 1'b1; ls_addr = v.addr; ls_wen = v.wen;
            ls_wdata = v.wdata; ls_wmask = v.wmask;
        end else begin
            if_valid = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(posedge clk); #1;
            if (sram_valid) begin
                if (sv_cnt == 0) begin
                    check($sformatf("v%0d sram_addr", idx), sram_addr, v.addr);
                    check($sformatf("v%0d sram_wen", idx), sram_wen, v.is_lsu ? v.wen : 1'b0);
                    check($sformatf("v%0d sram_wmask", idx), sram_wmask, v.is_lsu ? v.wmask : 4'h0);
                    if (v.is_lsu && v.wen)
                        check($sformatf("v%0d sram_wdata", idx), sram_wdata, v.wdata);
                end
                sv_cnt++;
            end
            if (v.is_lsu ? if_ready : ls_ready) other = 1'b1;
            if (v.is_lsu ? ls_ready : if_ready) begin
                got = c;
                rd = v.is_lsu ? ls_rdata : if_rdata;
                er = v.is_lsu ? ls_err : if_err;
            end
        end
        drive_idle();
        check($sformatf("v%0d latency", idx), got, v.exp_edges);
        check($sformatf("v%0d sram_valid cycles", idx), sv_cnt, v.exp_sv_cycles);
        if (!(v.is_lsu && v.wen))
            check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
        check($sformatf("v%0d err", idx), er, v.exp_err);
        check($sformatf("v%0d other ready", idx), other, 1'b0);
        $display("vec %0d %s addr=%h lat=%0d edges=%0d rdata=%h err=%0d",
                 idx, v.is_lsu ? "LSU" : "IFU", v.addr, v.lat, got, rd, er);
        @(posedge clk); #1;   // RESP -> IDLE
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sram_valid"}, sram_valid, 1'b0);
        check({tag, " sram_addr"},  sram_addr,  32'h0);
        check({tag, " sram_wen"},   sram_wen,   1'b0);
        check({tag, " sram_wdata"}, sram_wdata, 32'h0);
        check({tag, " sram_wmask"}, sram_wmask, 4'h0);
        check({tag, " readies"},    {if_ready, ls_ready, if_err, ls_err}, 4'h0);
        check({tag, " rdata"},      {if_rdata, ls_rdata}, 64'h0);
    endtask

    initial begin
        int q_order[$];
        bit seen;

        vecs[0] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0010_0073, 2, 1, 32'h0010_0073, 1'b0};
        vecs[1] = '{1'b1, 32'h8000_0100, 1'b1, 32'h1234_5678, 4'b0011, 0, 32'hAAAA_5555, 2, 1, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 4, 3, 32'hCAFE_F00D, 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0300, 1'b0, 32'h0, 4'h0, 99, 32'h1111_2222, 5, 4, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b0, 32'h8000_0400, 1'b0, 32'h0, 4'h0, 3, 32'h0000_1234, 5, 4, 32'h0000_1234, 1'b0};
        vecs[5] = '{1'b0, 32'h8000_0500, 1'b0, 32'h0, 4'h0, 99, 32'h5555_6666, 5, 4, 32'hDEAD_BEEF, 1'b1};

        rst = 1'b1;
        sram_rdata = '0;
        sram_ready = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Contention: both valid in the same IDLE cycle -> LSU then IFU
        resp_lat = 1;
        sram_rdata = 32'h0BAD_F00D;
        if_valid = 1'b1; if_addr = 32'h8000_1000;
        ls_valid = 1'b1; ls_addr = 32'h8000_2000; ls_wen = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && (if_valid || ls_valid); c++) begin
            @(posedge clk); #1;
            if (sram_valid && !seen) begin
                check("contention first addr", sram_addr, 32'h8000_2000);
                seen = 1'b1;
            end
            if (if_ready && ls_ready) check("contention double ready", 1'b1, 1'b0);
            if (ls_ready) begin q_order.push_back(1); ls_valid = 1'b0; end
            if (if_ready) begin q_order.push_back(0); if_valid = 1'b0; end
        end
        check("contention count", q_order.size(), 2);
        if (q_order.size() == 2) begin
            check("contention first", q_order[0], 1);
            check("contention second", q_order[1], 0);
        end
        $display("contention order size=%0d", q_order.size());
        drive_idle();
        @(posedge clk); #1;

        // Reset while in REQ
        resp_lat = 99;
        ls_valid = 1'b1; ls_addr = 32'h8000_3000; ls_wen = 1'b1;
        ls_wdata = 32'hFFFF_0000; ls_wmask = 4'hF;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(posedge clk); #1;
            seen = sram_valid;
        end
        check("reset-in-req reached REQ", seen, 1'b1);
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        check_reset_outputs("mid reset");
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (if_ready || ls_ready || sram_valid) seen = 1'b1;
        end
        check("no pulse after reset", seen, 1'b0);
        $display("reset in REQ done");
        run_vec(6, vecs[2]);

        // Stray sram_ready while IDLE
        stray_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (if_ready || ls_ready || sram_valid) seen = 1'b1;
        end
        stray_ready = 1'b0;
        check("stray ready ignored", seen, 1'b0);
        $display("stray sram_ready done");
        @(posedge clk); #1;
        run_vec(7, vecs[0]);

        // Randomized traffic against a timestamp model: a request accepted
        // at edge a with SRAM latency L is answered at edge a+1+min(L,TO-1);
        // the arbiter can accept again two edges after the answer.
        begin
            bit if_pend = 0, ls_pend = 0, active = 0;
            bit owner_lsu = 0, if_v, ls_v, is_to;
            int next_ok = 1, acc_e = 0, resp_e = 0, lat = 0, ntx = 0;
            logic [31:0] exp_rd = '0;
            for (int e = 1; e <= 1500; e++) begin
                if_v = if_pend;
                ls_v = ls_pend;
                @(posedge clk); #1;
                if (!active && e >= next_ok && (if_v || ls_v)) begin
                    owner_lsu  = ls_v;
                    lat        = $urandom_range(0, 5);
                    resp_lat   = lat;
                    exp_rd     = $urandom;
                    sram_rdata = exp_rd;
                    is_to      = (lat >= TO);
                    acc_e      = e;
                    resp_e     = e + 1 + ((lat < TO) ? lat : TO - 1);
                    active     = 1'b1;
                end
                check("rnd sram_valid", sram_valid, active && e >= acc_e && e < resp_e);
                if (active && e >= acc_e && e < resp_e) begin
                    check("rnd sram_addr", sram_addr, owner_lsu ? ls_addr : if_addr);
                    check("rnd sram_wen", sram_wen, owner_lsu ? ls_wen : 1'b0);
                    check("rnd sram_wmask", sram_wmask, owner_lsu ? ls_wmask : 4'h0);
                    if (owner_lsu && ls_wen) check("rnd sram_wdata", sram_wdata, ls_wdata);
                end
                check("rnd if_ready", if_ready, active && e == resp_e && !owner_lsu);
                check("rnd ls_ready", ls_ready, active && e == resp_e && owner_lsu);
                if (active && e == resp_e) begin
                    if (owner_lsu) begin
                        if (!ls_wen) check("rnd ls_rdata", ls_rdata, is_to ? 32'hDEAD_BEEF : exp_rd);
                        check("rnd ls_err", ls_err, is_to);
                        ls_pend = 1'b0; ls_valid = 1'b0;
                    end else begin
                        check("rnd if_rdata", if_rdata, is_to ? 32'hDEAD_BEEF : exp_rd);
                        check("rnd if_err", if_err, is_to);
                        if_pend = 1'b0; if_valid = 1'b0;
                    end
                    ntx++;
                    $display("rnd txn %0d %s lat=%0d timeout=%0d", ntx,
                             owner_lsu ? "LSU" : "IFU", lat, is_to);
                    active  = 1'b0;
                    next_ok = e + 2;
                end
                if (e < 1480) begin
                    if (!if_pend && $urandom_range(0, 1) == 1) begin
                        if_pend = 1'b1; if_valid = 1'b1; if_addr = $urandom;
                    end
                    if (!ls_pend && $urandom_range(0, 1) == 1) begin
                        ls_pend = 1'b1; ls_valid = 1'b1; ls_addr = $urandom;
                        ls_wen = $urandom_range(0, 1); ls_wdata = $urandom;
                        ls_wmask = 4'($urandom_range(0, 15));
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
